// File: rtl/logic_axi4_lite_pkg.sv
// logic_axi4_lite_pkg: shared AXI4-Lite field types
package logic_axi4_lite_pkg;

   typedef struct packed {
      logic instruction;
      logic non_secure;
      logic privileged;
   } access_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } response_t;

endpackage

// File: rtl/logic_axi4_lite_buffer_queue.sv
// logic_axi4_lite_buffer_queue: first-word-fall-through FIFO, valid/ready on both sides
module logic_axi4_lite_buffer_queue #(
   parameter int WIDTH    = 1,
   parameter int CAPACITY = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = $clog2(CAPACITY);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [CAPACITY];
   logic             full, empty, push, pop;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = wr_ptr == rd_ptr;
   // readiness never looks at out_ready, so a full queue refuses a push even while popping
   assign in_ready  = !rst && !full;
   assign out_valid = !rst && !empty;
   assign out_data  = rst ? '0 : mem[rd_ptr[AW-1:0]];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/logic_axi4_lite_buffer.sv
// logic_axi4_lite_buffer: per-channel AXI4-Lite elastic buffer with outstanding-credit limits
module logic_axi4_lite_buffer
   import logic_axi4_lite_pkg::*;
#(
   parameter int DATA_BYTES      = 4,
   parameter int ADDRESS_WIDTH   = 1,
   parameter int CAPACITY        = 4,
   parameter int MAX_OUTSTANDING = CAPACITY
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     slave_awvalid,
   input  logic [ADDRESS_WIDTH-1:0] slave_awaddr,
   input  access_t                  slave_awprot,
   output logic                     slave_awready,
   input  logic                     slave_wvalid,
   input  logic [DATA_BYTES*8-1:0]  slave_wdata,
   input  logic [DATA_BYTES-1:0]    slave_wstrb,
   output logic                     slave_wready,
   input  logic                     slave_bready,
   output logic                     slave_bvalid,
   output response_t                slave_bresp,
   input  logic                     slave_arvalid,
   input  logic [ADDRESS_WIDTH-1:0] slave_araddr,
   input  access_t                  slave_arprot,
   output logic                     slave_arready,
   input  logic                     slave_rready,
   output logic                     slave_rvalid,
   output logic [DATA_BYTES*8-1:0]  slave_rdata,
   output response_t                slave_rresp,
   output logic                     master_awvalid,
   output logic [ADDRESS_WIDTH-1:0] master_awaddr,
   output access_t                  master_awprot,
   input  logic                     master_awready,
   output logic                     master_wvalid,
   output logic [DATA_BYTES*8-1:0]  master_wdata,
   output logic [DATA_BYTES-1:0]    master_wstrb,
   input  logic                     master_wready,
   input  logic                     master_bvalid,
   input  response_t                master_bresp,
   output logic                     master_bready,
   output logic                     master_arvalid,
   output logic [ADDRESS_WIDTH-1:0] master_araddr,
   output access_t                  master_arprot,
   input  logic                     master_arready,
   input  logic                     master_rvalid,
   input  logic [DATA_BYTES*8-1:0]  master_rdata,
   input  response_t                master_rresp,
   output logic                     master_rready
);

   localparam int DW  = DATA_BYTES * 8;
   localparam int AXW = ADDRESS_WIDTH + $bits(access_t);
   localparam int WW  = DW + DATA_BYTES;
   localparam int BW  = $bits(response_t);
   localparam int RW  = DW + BW;
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   logic [CW-1:0]  wr_cnt, rd_cnt;
   logic           aw_credit, ar_credit, aw_ready, ar_ready;
   logic           aw_hs, b_hs, ar_hs, r_hs;
   logic [AXW-1:0] aw_out, ar_out;
   logic [WW-1:0]  w_out;
   logic [BW-1:0]  b_out;
   logic [RW-1:0]  r_out;

   assign aw_credit     = wr_cnt < CW'(MAX_OUTSTANDING);
   assign ar_credit     = rd_cnt < CW'(MAX_OUTSTANDING);
   assign slave_awready = aw_ready && aw_credit;
   assign slave_arready = ar_ready && ar_credit;
   assign aw_hs         = slave_awvalid && slave_awready;
   assign b_hs          = slave_bvalid && slave_bready;
   assign ar_hs         = slave_arvalid && slave_arready;
   assign r_hs          = slave_rvalid && slave_rready;

   logic_axi4_lite_buffer_queue #(.WIDTH(AXW), .CAPACITY(CAPACITY)) u_aw (
      .clk(aclk), .rst(areset),
      .in_valid(slave_awvalid && aw_credit), .in_ready(aw_ready), .in_data({slave_awprot, slave_awaddr}),
      .out_valid(master_awvalid), .out_ready(master_awready), .out_data(aw_out)
   );

   // W is deliberately not credit-gated: it may run ahead of or behind its AW
   logic_axi4_lite_buffer_queue #(.WIDTH(WW), .CAPACITY(CAPACITY)) u_w (
      .clk(aclk), .rst(areset),
      .in_valid(slave_wvalid), .in_ready(slave_wready), .in_data({slave_wstrb, slave_wdata}),
      .out_valid(master_wvalid), .out_ready(master_wready), .out_data(w_out)
   );

   logic_axi4_lite_buffer_queue #(.WIDTH(BW), .CAPACITY(CAPACITY)) u_b (
      .clk(aclk), .rst(areset),
      .in_valid(master_bvalid), .in_ready(master_bready), .in_data(master_bresp),
      .out_valid(slave_bvalid), .out_ready(slave_bready), .out_data(b_out)
   );

   logic_axi4_lite_buffer_queue #(.WIDTH(AXW), .CAPACITY(CAPACITY)) u_ar (
      .clk(aclk), .rst(areset),
      .in_valid(slave_arvalid && ar_credit), .in_ready(ar_ready), .in_data({slave_arprot, slave_araddr}),
      .out_valid(master_arvalid), .out_ready(master_arready), .out_data(ar_out)
   );

   logic_axi4_lite_buffer_queue #(.WIDTH(RW), .CAPACITY(CAPACITY)) u_r (
      .clk(aclk), .rst(areset),
      .in_valid(master_rvalid), .in_ready(master_rready), .in_data({master_rresp, master_rdata}),
      .out_valid(slave_rvalid), .out_ready(slave_rready), .out_data(r_out)
   );

   assign {master_awprot, master_awaddr} = aw_out;
   assign {master_arprot, master_araddr} = ar_out;
   assign {master_wstrb, master_wdata}   = w_out;
   assign slave_bresp                    = response_t'(b_out);
   assign slave_rresp                    = response_t'(r_out[DW +: BW]);
   assign slave_rdata                    = r_out[DW-1:0];

   // credits bound responses in flight, which is what keeps the B and R queues from filling
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         wr_cnt <= wr_cnt + CW'(aw_hs) - CW'(b_hs);
         rd_cnt <= rd_cnt + CW'(ar_hs) - CW'(r_hs);
      end
   end

   a_b_room:      assert property (@(posedge aclk) disable iff (areset) !(master_bvalid && !master_bready));
   a_r_room:      assert property (@(posedge aclk) disable iff (areset) !(master_rvalid && !master_rready));
   a_wr_underrun: assert property (@(posedge aclk) disable iff (areset) !(b_hs && wr_cnt == '0));
   a_rd_underrun: assert property (@(posedge aclk) disable iff (areset) !(r_hs && rd_cnt == '0));

endmodule

// File: tb/tb_logic_axi4_lite_buffer.sv
// tb_logic_axi4_lite_buffer: directed and randomized checks against a queue-based reference model
module tb_logic_axi4_lite_buffer;
   import logic_axi4_lite_pkg::*;

   localparam int CAP = 4;
   localparam int MAX = 3;

   logic aclk = 1'b0, areset;
   logic slave_awvalid, slave_awready, slave_wvalid, slave_wready, slave_bready, slave_bvalid;
   logic slave_arvalid, slave_arready, slave_rready, slave_rvalid;
   logic master_awvalid, master_awready, master_wvalid, master_wready, master_bvalid, master_bready;
   logic master_arvalid, master_arready, master_rvalid, master_rready;
   logic [7:0] slave_awaddr, slave_araddr, master_awaddr, master_araddr;
   logic [31:0] slave_wdata, slave_rdata, master_wdata, master_rdata;
   logic [3:0] slave_wstrb, master_wstrb;
   access_t slave_awprot, slave_arprot, master_awprot, master_arprot;
   response_t slave_bresp, slave_rresp, master_bresp, master_rresp;

   logic_axi4_lite_buffer #(.DATA_BYTES(4), .ADDRESS_WIDTH(8), .CAPACITY(CAP), .MAX_OUTSTANDING(MAX)) dut (
      .aclk(aclk), .areset(areset),
      .slave_awvalid(slave_awvalid), .slave_awaddr(slave_awaddr), .slave_awprot(slave_awprot), .slave_awready(slave_awready),
      .slave_wvalid(slave_wvalid), .slave_wdata(slave_wdata), .slave_wstrb(slave_wstrb), .slave_wready(slave_wready),
      .slave_bready(slave_bready), .slave_bvalid(slave_bvalid), .slave_bresp(slave_bresp),
      .slave_arvalid(slave_arvalid), .slave_araddr(slave_araddr), .slave_arprot(slave_arprot), .slave_arready(slave_arready),
      .slave_rready(slave_rready), .slave_rvalid(slave_rvalid), .slave_rdata(slave_rdata), .slave_rresp(slave_rresp),
      .master_awvalid(master_awvalid), .master_awaddr(master_awaddr), .master_awprot(master_awprot), .master_awready(master_awready),
      .master_wvalid(master_wvalid), .master_wdata(master_wdata), .master_wstrb(master_wstrb), .master_wready(master_wready),
      .master_bvalid(master_bvalid), .master_bresp(master_bresp), .master_bready(master_bready),
      .master_arvalid(master_arvalid), .master_araddr(master_araddr), .master_arprot(master_arprot), .master_arready(master_arready),
      .master_rvalid(master_rvalid), .master_rdata(master_rdata), .master_rresp(master_rresp), .master_rready(master_rready)
   );

   always #5 aclk = ~aclk;

   // reference model: one queue per channel plus outstanding counts
   logic [10:0] awq[$], arq[$];
   logic [35:0] wq[$];
   logic [1:0]  bq[$];
   logic [33:0] rq[$];
   logic [7:0]  pend_r[$];
   int pend_b = 0, wr = 0, rd = 0;
   logic aw_hold = 0, w_hold = 0, ar_hold = 0;
   int vectors = 0, miscompares = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic pct(int p);
      return $urandom_range(99, 0) < p;
   endfunction

   task automatic check_outputs();
      if (areset) begin
         chk("rst_req", {master_awvalid, master_awaddr, master_awprot, master_arvalid, master_araddr, master_arprot,
                         slave_awready, slave_arready, slave_wready}, '0);
         chk("rst_w", {master_wvalid, master_wstrb, master_wdata}, '0);
         chk("rst_rsp", {slave_bvalid, slave_bresp, slave_rvalid, slave_rresp, slave_rdata, master_bready, master_rready}, '0);
      end else begin
         chk("s_awready", slave_awready, awq.size() < CAP && wr < MAX);
         chk("s_wready", slave_wready, wq.size() < CAP);
         chk("s_arready", slave_arready, arq.size() < CAP && rd < MAX);
         chk("m_bready", master_bready, bq.size() < CAP);
         chk("m_rready", master_rready, rq.size() < CAP);
         chk("m_awvalid", master_awvalid, awq.size() > 0);
         chk("m_wvalid", master_wvalid, wq.size() > 0);
         chk("s_bvalid", slave_bvalid, bq.size() > 0);
         chk("m_arvalid", master_arvalid, arq.size() > 0);
         chk("s_rvalid", slave_rvalid, rq.size() > 0);
         if (awq.size() > 0) chk("m_aw", {master_awprot, master_awaddr}, awq[0]);
         if (wq.size() > 0) chk("m_w", {master_wstrb, master_wdata}, wq[0]);
         if (bq.size() > 0) chk("s_b", slave_bresp, bq[0]);
         if (arq.size() > 0) chk("m_ar", {master_arprot, master_araddr}, arq[0]);
         if (rq.size() > 0) chk("s_r", {slave_rresp, slave_rdata}, rq[0]);
      end
   endtask

   task automatic model_update();
      logic aw_in, aw_out, w_in, w_out, b_in, b_out, ar_in, ar_out, r_in, r_out;
      if (areset) begin
         awq.delete(); wq.delete(); bq.delete(); arq.delete(); rq.delete(); pend_r.delete();
         pend_b = 0; wr = 0; rd = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
         return;
      end
      aw_in  = slave_awvalid && awq.size() < CAP && wr < MAX;
      aw_out = awq.size() > 0 && master_awready;
      w_in   = slave_wvalid && wq.size() < CAP;
      w_out  = wq.size() > 0 && master_wready;
      b_in   = master_bvalid && bq.size() < CAP;
      b_out  = bq.size() > 0 && slave_bready;
      ar_in  = slave_arvalid && arq.size() < CAP && rd < MAX;
      ar_out = arq.size() > 0 && master_arready;
      r_in   = master_rvalid && rq.size() < CAP;
      r_out  = rq.size() > 0 && slave_rready;
      if (aw_out) pend_b++;
      if (b_in) pend_b--;
      if (ar_out) pend_r.push_back(arq[0][7:0]);
      if (r_in) void'(pend_r.pop_front());
      if (aw_out) void'(awq.pop_front());
      if (w_out) void'(wq.pop_front());
      if (b_out) void'(bq.pop_front());
      if (ar_out) void'(arq.pop_front());
      if (r_out) void'(rq.pop_front());
      if (aw_in) awq.push_back({slave_awprot, slave_awaddr});
      if (w_in) wq.push_back({slave_wstrb, slave_wdata});
      if (b_in) bq.push_back(master_bresp);
      if (ar_in) arq.push_back({slave_arprot, slave_araddr});
      if (r_in) rq.push_back({master_rresp, master_rdata});
      wr += int'(aw_in) - int'(b_out);
      rd += int'(ar_in) - int'(r_out);
      aw_hold = slave_awvalid && !aw_in;
      w_hold  = slave_wvalid && !w_in;
      ar_hold = slave_arvalid && !ar_in;
   endtask

   task automatic step();
      #1 check_outputs();
      @(posedge aclk);
      model_update();
      @(negedge aclk);
   endtask

   task automatic zero_inputs();
      slave_awvalid = 0; slave_awaddr = '0; slave_awprot = '0;
      slave_wvalid = 0; slave_wdata = '0; slave_wstrb = '0;
      slave_arvalid = 0; slave_araddr = '0; slave_arprot = '0;
      slave_bready = 1; slave_rready = 1;
      master_awready = 1; master_wready = 1; master_arready = 1;
      master_bvalid = 0; master_bresp = RESP_OKAY;
      master_rvalid = 0; master_rdata = '0; master_rresp = RESP_OKAY;
   endtask

   task automatic rand_inputs(int preq, int prsp, int prdy);
      if (!aw_hold) begin
         slave_awvalid = pct(preq); slave_awaddr = 8'($urandom); slave_awprot = access_t'(3'($urandom));
      end
      if (!w_hold) begin
         slave_wvalid = pct(preq); slave_wdata = $urandom; slave_wstrb = 4'($urandom);
      end
      if (!ar_hold) begin
         slave_arvalid = pct(preq); slave_araddr = 8'($urandom); slave_arprot = access_t'(3'($urandom));
      end
      master_awready = pct(prdy); master_wready = pct(prdy); master_arready = pct(prdy);
      slave_bready = pct(prdy); slave_rready = pct(prdy);
      master_bvalid = pend_b > 0 && pct(prsp);
      master_bresp = response_t'(2'($urandom));
      master_rvalid = pend_r.size() > 0 && pct(prsp);
      master_rdata = pend_r.size() > 0 ? 32'(pend_r[0]) + 32'h100 : 32'h0;
      master_rresp = response_t'(2'($urandom));
   endtask

   initial begin
      zero_inputs();
      areset = 1;
      @(negedge aclk);
      repeat (2) step();
      areset = 0;
      // single write: AW and W forwarded after one edge, B returned
      slave_awvalid = 1; slave_awaddr = 8'h01;
      slave_wvalid = 1; slave_wdata = 32'hDEADBEEF; slave_wstrb = 4'hF;
      master_awready = 0; master_wready = 0;
      step();
      chk("t1_aw", {master_awvalid, master_awprot, master_awaddr}, {1'b1, 3'b000, 8'h01});
      chk("t1_w", {master_wvalid, master_wstrb, master_wdata}, {1'b1, 4'hF, 32'hDEADBEEF});
      zero_inputs();
      step();
      master_bvalid = 1; master_bresp = RESP_OKAY; slave_bready = 0;
      step();
      chk("t1_b", {slave_bvalid, slave_bresp}, {1'b1, 2'b00});
      zero_inputs();
      step();
      // credit limit: AWs accepted until MAX are outstanding
      slave_bready = 0; slave_awvalid = 1; slave_awaddr = 8'h10;
      repeat (3) step();
      chk("credit_stall", slave_awready, 1'b0);
      slave_awvalid = 0; master_bvalid = 1;
      step();
      master_bvalid = 0; slave_bready = 1;
      step();
      chk("credit_back", slave_awready, 1'b1);
      repeat (10) begin rand_inputs(0, 100, 100); step(); end
      // W is not credit-gated, so it fills its queue
      zero_inputs();
      master_wready = 0; slave_wvalid = 1;
      repeat (4) begin slave_wdata = $urandom; step(); end
      chk("w_full", slave_wready, 1'b0);
      slave_wvalid = 0; master_wready = 1;
      repeat (5) step();
      // randomized traffic under several load profiles
      repeat (600) begin rand_inputs(60, 60, 60); step(); end
      repeat (600) begin rand_inputs(90, 50, 20); step(); end
      repeat (600) begin rand_inputs(100, 100, 100); step(); end
      // reset with traffic in flight
      repeat (40) begin rand_inputs(80, 50, 40); step(); end
      areset = 1;
      rand_inputs(80, 50, 40);
      step();
      areset = 0;
      zero_inputs();
      step();
      chk("post_rst_rdy", {slave_awready, slave_arready, slave_wready}, 3'b111);
      chk("post_rst_vld", {master_awvalid, master_wvalid, master_arvalid, slave_bvalid, slave_rvalid}, 5'b0);
      repeat (600) begin rand_inputs(70, 70, 70); step(); end
      repeat (40) begin rand_inputs(0, 100, 100); step(); end
      chk("drained", {slave_awready, slave_arready, master_awvalid, master_arvalid, slave_bvalid, slave_rvalid}, 6'b110000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
